fetch_queue: RTL
================

# fetch_queue

Three-wide instruction fetch queue that sits between the instruction fetch unit (`iunit`) and the decode/issue stage of the superscalar MIPS pipeline.
- Each cycle it accepts up to three {PC, instruction} pairs in program order from fetch.
- It presents up to three of the oldest entries to decode, and decode takes 0–3 of them per cycle.
- It decouples fetch from issue stalls and empties on a branch/jump redirect (`flush`).

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Must be a power of two and at least 4.
- `W`, 32: width of the instruction word and of the PC.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous reset, active-high.
- `flush` in 1: discard all entries (branch mispredict or taken jump).
- `enq_count` in 2: number of valid fetch slots this cycle (0–3). Slots are always packed as 0, then 1, then 2.
- `enq_pc0`, `enq_pc1`, `enq_pc2` in W: PC of each fetch slot.
- `enq_instr0`, `enq_instr1`, `enq_instr2` in W: instruction word of each fetch slot.
- `enq_ready` out 1: the queue has at least 3 free entries. Fetch may only push while this is high.
- `deq_avail` out 2: number of entries presented to decode, equal to min(count, 3).
- `deq_pc0`, `deq_pc1`, `deq_pc2` out W: PCs of the oldest entries. Slot 0 is the oldest.
- `deq_instr0`, `deq_instr1`, `deq_instr2` out W: instructions of the oldest entries.
- `deq_take` in 2: number of entries decode consumes this cycle.
- `count` out clog2(DEPTH)+1: current occupancy.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries, each {pc, instr}, with `head` (oldest entry) and `tail` (next free entry) pointers of width clog2(DEPTH).
- Pointers wrap modulo DEPTH naturally.
- **Enqueue:** if `enq_ready` and `enq_count` = n > 0, write slot i to entry `tail+i` for i < n, then advance `tail` by n.
  - If `enq_ready` is low, `enq_count` is ignored: nothing is written and `tail` does not move. This is a protocol violation and the bench flags it.
- **Dequeue:** the effective take is t = min(`deq_take`, `deq_avail`), so excess requests are clipped. `head` advances by t.
- **Read port:** output slot k shows entry `head+k` when k < `deq_avail`. Otherwise it drives PC = 0 and instr = 32'h00000000 (NOP).
- **Simultaneous enqueue and dequeue:**
  - count_next = count + n_accepted − t.
  - `enq_ready` is computed from the current count only. A dequeue in the same cycle does not free space early.
- **Priority:** `rst` > `flush` > enqueue/dequeue.
  - `flush` sets `head`, `tail` and count to 0 on the next edge.
  - Any enqueue or dequeue requested in the same cycle as `flush` is discarded.
- No state machine beyond the pointers and the count register. count is held explicitly, not derived from the pointers, so the full and empty cases are unambiguous.

## Timing
- Enqueue-to-visible latency is 1 cycle. Data written at edge E appears on the `deq_*` outputs after E, with no combinational bypass from `enq_*` to `deq_*`.
- The dequeue outputs are show-ahead: they are combinational from the registered `head`, count and storage. `deq_take` takes effect at the next edge.
- `enq_ready`, `deq_avail`, `empty` and `full` are combinational from the registered count, so there is no path from `enq_count` or `deq_take` to them.
- **Reset values** (on the first edge with `rst` high): `head` = `tail` = count = 0, `enq_ready` = 1, `deq_avail` = 0, `empty` = 1, `full` = 0, all `deq_pc*` and `deq_instr*` = 0.
  - The storage array itself is not reset.
- Reset asserted mid-operation behaves identically to a flush, plus it also overrides any flush.
- **Boundary conditions:**
  - count = DEPTH−3: `enq_ready` = 1.
  - count = DEPTH−2: `enq_ready` = 0.
  - count = DEPTH: `full` = 1.
  - count = 0 with `deq_take` = 3: no change and no underflow.
  - A write that spans the wrap (`tail` = DEPTH−1, n = 3) lands in entries DEPTH−1, 0 and 1.
- Sustained 3-in/3-out throughput is achieved whenever count ≤ DEPTH−3 and count ≥ 3.

## Structure
- Shared header `cpu_defs.vh` holds:
  - `NOP_INSTR` = 32'h00000000;
  - the default `DEPTH`;
  - the width macros reused by `iunit` and the decode stage.
- One sub-module, `fq_ram`: DEPTH×(2W) register-file storage with 3 write ports (per-port enables, addresses `tail+0..2`) and 3 asynchronous read ports (addresses `head+0..2`).
  - Writes within one cycle always target distinct addresses, so it needs no write-conflict resolution.
- The top level, `fetch_queue`, holds the pointers, the count, clipping and the output masking.

## Test plan
1. **Reset then push:** `rst`, then push 3 (PC 0x00/0x04/0x08, instr 0x20010001/0x20020002/0x20030003) → the next cycle shows `deq_avail` = 3, slot 0 = PC 0x00 with instr 0x20010001, and count = 3.
2. **Fill to stop:** push 3 per cycle with `deq_take` = 0 from empty, DEPTH = 8 → after two pushes count = 6 and `enq_ready` = 0. A third push is ignored and count stays 6.
3. **Wrap:** advance `head` and `tail` to 6, push 3 (PC 0x40/0x44/0x48) → entries 6, 7 and 0 hold them. Take 3 → outputs are in order 0x40, 0x44, 0x48, and `empty` = 1.
4. **Simultaneous enqueue and dequeue:** count = 4, push 3, `deq_take` = 2 → count = 5 and `deq_pc0` shows the third-oldest original entry.
5. **Flush priority:** count = 5, assert `flush` together with push 3 and `deq_take` = 3 → count = 0, `empty` = 1, and all `deq_*` = 0.
6. **Over-take clip:** count = 2, `deq_take` = 3 → count = 0 and no pointer corruption. A following push of 1 (PC 0x80) appears at `deq_pc0` with `deq_avail` = 1.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the three-wide fetch queue: default geometry,
// the NOP encoding driven on empty decode slots, and the take-clip helper.
package fetch_queue_pkg;

    localparam int          FQ_DEPTH  = 8;
    localparam int          FQ_W      = 32;
    localparam int          FQ_SLOTS  = 3;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Decode may ask for more entries than are presented; clip to what exists.
    function automatic logic [1:0] clip_take(input logic [1:0] take,
                                             input logic [1:0] avail);
        return (take > avail) ? avail : take;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// fq_ram: DEPTH x (2W) register-file storage for {pc, instr} entries.
// Three write ports addressed tail+0..2 and three asynchronous read ports
// addressed head+0..2. Writes in one cycle always hit distinct entries, so
// there is no write-conflict resolution. Storage is intentionally not reset.
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    parameter  int W     = FQ_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [FQ_SLOTS-1:0] we,
    input  logic [AW-1:0]       waddr0,
    input  logic [AW-1:0]       waddr1,
    input  logic [AW-1:0]       waddr2,
    input  logic [2*W-1:0]      wdata0,
    input  logic [2*W-1:0]      wdata1,
    input  logic [2*W-1:0]      wdata2,
    input  logic [AW-1:0]       raddr0,
    input  logic [AW-1:0]       raddr1,
    input  logic [AW-1:0]       raddr2,
    output logic [2*W-1:0]      rdata0,
    output logic [2*W-1:0]      rdata1,
    output logic [2*W-1:0]      rdata2
);

    logic [2*W-1:0] mem [DEPTH];

    // Per-port writes; addresses are tail-relative and never collide.
    always_ff @(posedge clk) begin
        if (we[0]) mem[waddr0] <= wdata0;
        if (we[1]) mem[waddr1] <= wdata1;
        if (we[2]) mem[waddr2] <= wdata2;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: three-wide in-order instruction queue between fetch and
// decode. Holds head/tail pointers and an explicit occupancy count, clips
// over-large dequeue requests, and masks unused decode slots to PC 0 / NOP.
//
// Handshake: fetch may push enq_count entries only while enq_ready is high
// (at least three free entries, judged from the registered count alone);
// pushes while enq_ready is low are ignored. Decode sees deq_avail entries
// show-ahead and consumes min(deq_take, deq_avail) of them at the next edge.
// flush (and rst above it) discards the queue and any same-cycle push/take.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    parameter  int W     = FQ_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [1:0]    enq_count,
    input  logic [W-1:0]  enq_pc0,
    input  logic [W-1:0]  enq_pc1,
    input  logic [W-1:0]  enq_pc2,
    input  logic [W-1:0]  enq_instr0,
    input  logic [W-1:0]  enq_instr1,
    input  logic [W-1:0]  enq_instr2,
    output logic          enq_ready,
    output logic [1:0]    deq_avail,
    output logic [W-1:0]  deq_pc0,
    output logic [W-1:0]  deq_pc1,
    output logic [W-1:0]  deq_pc2,
    output logic [W-1:0]  deq_instr0,
    output logic [W-1:0]  deq_instr1,
    output logic [W-1:0]  deq_instr2,
    input  logic [1:0]    deq_take,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [AW-1:0]       head_q;
    logic [AW-1:0]       tail_q;
    logic [CW-1:0]       count_q;
    logic [1:0]          n_acc;
    logic [1:0]          t_eff;
    logic [FQ_SLOTS-1:0] we;
    logic [2*W-1:0]      rdata0;
    logic [2*W-1:0]      rdata1;
    logic [2*W-1:0]      rdata2;

    // Status flags depend only on the registered count.
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign enq_ready = (count_q <= CW'(DEPTH - 3));
    assign deq_avail = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];

    assign n_acc = enq_ready ? enq_count : 2'd0;
    assign t_eff = clip_take(deq_take, deq_avail);

    // Slots are packed from 0, so slot i is written when more than i accepted.
    assign we = (rst || flush) ? '0
              : {(n_acc == 2'd3), (n_acc >= 2'd2), (n_acc >= 2'd1)};

    // Pointer and occupancy update: rst, then flush, then normal enq/deq.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + AW'(t_eff);
            tail_q  <= tail_q + AW'(n_acc);
            count_q <= count_q + CW'(n_acc) - CW'(t_eff);
        end
    end

    fq_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr0 (tail_q),
        .waddr1 (tail_q + AW'(1)),
        .waddr2 (tail_q + AW'(2)),
        .wdata0 ({enq_pc0, enq_instr0}),
        .wdata1 ({enq_pc1, enq_instr1}),
        .wdata2 ({enq_pc2, enq_instr2}),
        .raddr0 (head_q),
        .raddr1 (head_q + AW'(1)),
        .raddr2 (head_q + AW'(2)),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // Slots beyond deq_avail show PC 0 and a NOP rather than stale storage.
    assign deq_pc0    = (deq_avail > 2'd0) ? rdata0[2*W-1:W] : '0;
    assign deq_pc1    = (deq_avail > 2'd1) ? rdata1[2*W-1:W] : '0;
    assign deq_pc2    = (deq_avail > 2'd2) ? rdata2[2*W-1:W] : '0;
    assign deq_instr0 = (deq_avail > 2'd0) ? rdata0[W-1:0]   : W'(NOP_INSTR);
    assign deq_instr1 = (deq_avail > 2'd1) ? rdata1[W-1:0]   : W'(NOP_INSTR);
    assign deq_instr2 = (deq_avail > 2'd2) ? rdata2[W-1:0]   : W'(NOP_INSTR);

endmodule
